// File: rtl/madnes_bus_pkg.sv
// Shared types for the MCU register-write path feeding control_registers.
package madnes_bus_pkg;

    // Default widths matching the control_registers write port
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;

    // One buffered register write
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } reg_write_t;

    // Capture FSM: IDLE waits for a bus write to start, STROBE waits for it to end
    typedef enum logic {
        IDLE   = 1'b0,
        STROBE = 1'b1
    } cap_state_t;

endpackage

// File: rtl/reg_write_fifo.sv
// Synchronous FIFO of packed {addr,data} register writes. A push while full is
// accepted only when a pop happens in the same cycle; otherwise it is ignored
// (the parent flags the drop). Pointers wrap naturally because DEPTH is a power of 2.
module reg_write_fifo
    import madnes_bus_pkg::*;
#(
    parameter int W     = DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          do_push;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && (!full || pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Occupancy next-state: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mcu_write_bridge.sv
// Bridges asynchronous MCU bus writes into clk, buffers them, and replays them as
// single-cycle register write strobes only while commit_allow (vblank) is high.
// addr/data are sampled raw at push time; the bus guarantees they are stable then.
module mcu_write_bridge
    import madnes_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ebi_cs_n,
    input  logic                          ebi_we_n,
    input  logic [ADDR_W-1:0]             ebi_addr,
    input  logic [DATA_W-1:0]             ebi_data,
    input  logic                          commit_allow,
    input  logic                          overflow_clr,
    output logic [ADDR_W-1:0]             write_addr,
    output logic [DATA_W-1:0]             write_data,
    output logic                          write_enable,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int W = ADDR_W + DATA_W;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] we_sync_q;
    logic                   cs_s;
    logic                   we_s;
    cap_state_t             state_q;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_empty;
    logic [W-1:0]           fifo_rdata;
    logic [ADDR_W-1:0]      write_addr_q;
    logic [DATA_W-1:0]      write_data_q;
    logic                   write_enable_q;
    logic                   overflow_q;

    // Synchronisers preset to 1 so reset looks like an idle bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q <= '1;
            we_sync_q <= '1;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], ebi_cs_n};
            we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], ebi_we_n};
        end
    end

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign we_s = we_sync_q[SYNC_STAGES-1];

    // In STROBE both strobes were low, so we_s high means it just rose: a completed
    // write (including cs_s rising together). cs_s alone rising is an aborted cycle.
    assign push = (state_q == STROBE) && we_s;

    // Capture FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!cs_s && !we_s) state_q <= STROBE;
                STROBE:  if (we_s || cs_s)   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop  = commit_allow && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    reg_write_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({ebi_addr, ebi_data}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Drain register: one strobe per pop, address/data hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_addr_q   <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
        end else begin
            write_enable_q <= pop;
            if (pop) {write_addr_q, write_data_q} <= fifo_rdata;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (overflow_clr) overflow_q <= 1'b0;
    end

    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign write_enable = write_enable_q;
    assign overflow     = overflow_q;

endmodule
